// File: rtl/rv_defs.sv
// Shared encodings for the uRV memory/writeback stage: access codes, FSM
// states and the lane helpers used to decode loads and stores.
package rv_defs;

  localparam logic [2:0] FUNC_LB  = 3'd0;
  localparam logic [2:0] FUNC_LH  = 3'd1;
  localparam logic [2:0] FUNC_LW  = 3'd2;
  localparam logic [2:0] FUNC_LBU = 3'd4;
  localparam logic [2:0] FUNC_LHU = 3'd5;
  localparam logic [2:0] FUNC_SB  = 3'd0;
  localparam logic [2:0] FUNC_SH  = 3'd1;
  localparam logic [2:0] FUNC_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_LOAD  = 2'd1,
    ST_WAIT_STORE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  select;
  } store_lanes_t;

  // Size lives in fun[1:0] for loads and stores alike (LBU/LHU differ only in fun[2]).
  function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic store_lanes_t store_lanes(input logic [2:0] fun, input logic [31:0] data,
                                               input logic [1:0] lane);
    store_lanes_t st;
    case (fun)
      FUNC_SB: begin
        st.data   = {4{data[7:0]}};
        st.select = 4'b0001 << lane;
      end
      FUNC_SH: begin
        st.data   = {2{data[15:0]}};
        st.select = 4'b0011 << lane;
      end
      default: begin
        st.data   = data;
        st.select = 4'b1111;
      end
    endcase
    return st;
  endfunction

endpackage

// File: rtl/rv_load_align.sv
// Picks the addressed byte/half/word out of a loaded memory word and
// sign- or zero-extends it according to the load type.
module rv_load_align
  import rv_defs::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  fun_i,
  output logic [31:0] value_o
);

  logic [31:0] shifted_s;

  // Lane extraction followed by extension.
  always_comb begin
    shifted_s = data_i >> {lane_i, 3'b000};
    case (fun_i)
      FUNC_LB:  value_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      FUNC_LH:  value_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      FUNC_LW:  value_o = shifted_s;
      FUNC_LBU: value_o = {24'd0, shifted_s[7:0]};
      FUNC_LHU: value_o = {16'd0, shifted_s[15:0]};
      default:  value_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/rv_mem_stage.sv
// uRV memory/writeback stage: issues data-memory requests, stalls the pipeline
// until they complete, and drives the register-file write port.
module rv_mem_stage
  import rv_defs::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_addr_i,
  input  logic [31:0] x_store_data_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  output logic        w_stall_req_o,
  output logic        w_misaligned_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_s_o,
  output logic [3:0]  dm_data_select_o,
  output logic        dm_load_o,
  output logic        dm_store_o,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  input  logic [31:0] dm_data_l_i,
  output logic        rf_write_o,
  output logic [4:0]  rf_index_o,
  output logic [31:0] rf_data_o
);

  state_e       state_r;
  logic [2:0]   fun_r;
  logic [1:0]   lane_r;
  logic [4:0]   rd_r;
  logic         misaligned_s;
  store_lanes_t store_s;
  logic [31:0]  load_value_s;

  // Decode of the operation currently presented by execute.
  always_comb begin
    misaligned_s = (x_load_i || x_store_i) && access_misaligned(x_fun_i[1:0], x_addr_i[1:0]);
    store_s      = store_lanes(x_fun_i, x_store_data_i, x_addr_i[1:0]);
  end

  rv_load_align u_load_align (
    .data_i  (dm_data_l_i),
    .lane_i  (lane_r),
    .fun_i   (fun_r),
    .value_o (load_value_s)
  );

  // Stage FSM with registered memory, stall and writeback outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r          <= ST_IDLE;
      fun_r            <= 3'd0;
      lane_r           <= 2'd0;
      rd_r             <= 5'd0;
      w_stall_req_o    <= 1'b0;
      w_misaligned_o   <= 1'b0;
      dm_addr_o        <= 32'd0;
      dm_data_s_o      <= 32'd0;
      dm_data_select_o <= 4'd0;
      dm_load_o        <= 1'b0;
      dm_store_o       <= 1'b0;
      rf_write_o       <= 1'b0;
      rf_index_o       <= 5'd0;
      rf_data_o        <= 32'd0;
    end else begin
      dm_load_o      <= 1'b0;
      dm_store_o     <= 1'b0;
      w_misaligned_o <= 1'b0;
      rf_write_o     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (x_valid_i) begin
            if (misaligned_s) begin
              w_misaligned_o <= 1'b1;
            end else if (x_load_i) begin
              dm_addr_o     <= {x_addr_i[31:2], 2'b00};
              dm_load_o     <= 1'b1;
              fun_r         <= x_fun_i;
              lane_r        <= x_addr_i[1:0];
              rd_r          <= x_rd_i;
              w_stall_req_o <= 1'b1;
              state_r       <= ST_WAIT_LOAD;
            end else if (x_store_i) begin
              dm_addr_o        <= {x_addr_i[31:2], 2'b00};
              dm_data_s_o      <= store_s.data;
              dm_data_select_o <= store_s.select;
              dm_store_o       <= 1'b1;
              w_stall_req_o    <= 1'b1;
              state_r          <= ST_WAIT_STORE;
            end else if (x_rd_write_i && (x_rd_i != 5'd0)) begin
              rf_write_o <= 1'b1;
              rf_index_o <= x_rd_i;
              rf_data_o  <= x_rd_value_i;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (dm_load_done_i) begin
            state_r       <= ST_IDLE;
            w_stall_req_o <= 1'b0;
            // rd=0 still completes the load, it just never reaches the register file.
            if (rd_r != 5'd0) begin
              rf_write_o <= 1'b1;
              rf_index_o <= rd_r;
              rf_data_o  <= load_value_s;
            end
          end
        end
        ST_WAIT_STORE: begin
          if (dm_store_done_i) begin
            state_r       <= ST_IDLE;
            w_stall_req_o <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          w_stall_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_stage.sv
// Directed and randomized checks of rv_mem_stage against a behavioural model
// of loads, stores, misalignment and writeback timing.
module tb_rv_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        x_valid_i = 1'b0;
  logic        x_load_i = 1'b0;
  logic        x_store_i = 1'b0;
  logic [2:0]  x_fun_i = 3'd0;
  logic [31:0] x_addr_i = 32'd0;
  logic [31:0] x_store_data_i = 32'd0;
  logic [4:0]  x_rd_i = 5'd0;
  logic [31:0] x_rd_value_i = 32'd0;
  logic        x_rd_write_i = 1'b0;
  logic        w_stall_req_o;
  logic        w_misaligned_o;
  logic [31:0] dm_addr_o;
  logic [31:0] dm_data_s_o;
  logic [3:0]  dm_data_select_o;
  logic        dm_load_o;
  logic        dm_store_o;
  logic        dm_load_done_i = 1'b0;
  logic        dm_store_done_i = 1'b0;
  logic [31:0] dm_data_l_i = 32'd0;
  logic        rf_write_o;
  logic [4:0]  rf_index_o;
  logic [31:0] rf_data_o;

  int checks = 0;
  int failures = 0;

  rv_mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .x_valid_i(x_valid_i), .x_load_i(x_load_i), .x_store_i(x_store_i),
    .x_fun_i(x_fun_i), .x_addr_i(x_addr_i), .x_store_data_i(x_store_data_i),
    .x_rd_i(x_rd_i), .x_rd_value_i(x_rd_value_i), .x_rd_write_i(x_rd_write_i),
    .w_stall_req_o(w_stall_req_o), .w_misaligned_o(w_misaligned_o),
    .dm_addr_o(dm_addr_o), .dm_data_s_o(dm_data_s_o), .dm_data_select_o(dm_data_select_o),
    .dm_load_o(dm_load_o), .dm_store_o(dm_store_o),
    .dm_load_done_i(dm_load_done_i), .dm_store_done_i(dm_store_done_i),
    .dm_data_l_i(dm_data_l_i),
    .rf_write_o(rf_write_o), .rf_index_o(rf_index_o), .rf_data_o(rf_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rules written from the access semantics with plain arithmetic.
  function automatic bit ref_misaligned(input int fun, input logic [31:0] addr);
    int sz;
    sz = fun % 4;
    if (sz == 1) return (addr % 2) != 0;
    if (sz == 2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] data, input logic [31:0] addr, input int fun);
    logic [31:0] v;
    int b;
    int h;
    v = data / (32'd1 << (8 * (addr % 4)));
    b = int'(v % 256);
    h = int'(v % 65536);
    case (fun)
      0: return (b >= 128) ? b - 256 : b;
      1: return (h >= 32768) ? h - 65536 : h;
      4: return b;
      5: return h;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] ref_store_data(input logic [31:0] d, input int fun);
    if (fun == 0) return (d % 256) * 32'h01010101;
    if (fun == 1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_store_sel(input logic [31:0] addr, input int fun);
    if (fun == 0) return 32'd1 << (addr % 4);
    if (fun == 1) return 32'd3 << (addr % 4);
    return 32'd15;
  endfunction

  task automatic drive_idle();
    x_valid_i = 1'b0; x_load_i = 1'b0; x_store_i = 1'b0; x_rd_write_i = 1'b0;
  endtask

  // Random traffic while the stage is busy; it must all be ignored.
  task automatic drive_junk(input bit is_load);
    int k;
    k = $urandom_range(0, 2);
    x_valid_i = 1'($urandom_range(0, 1));
    x_load_i = (k == 1); x_store_i = (k == 2);
    x_fun_i = 3'($urandom_range(0, 2)); x_addr_i = $urandom;
    x_rd_i = 5'($urandom_range(1, 31)); x_rd_write_i = 1'b1; x_rd_value_i = $urandom;
    if (is_load) dm_store_done_i = 1'($urandom_range(0, 1));
    else dm_load_done_i = 1'($urandom_range(0, 1));
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] val, input bit wr);
    x_valid_i = 1'b1; x_load_i = 1'b0; x_store_i = 1'b0; x_fun_i = 3'($urandom);
    x_addr_i = $urandom; x_rd_i = rd; x_rd_value_i = val; x_rd_write_i = wr;
    tick();
    drive_idle();
    chk("alu_rf_write", rf_write_o, (wr && rd != 5'd0) ? 32'd1 : 32'd0);
    chk("alu_stall", w_stall_req_o, 32'd0);
    chk("alu_no_dm", dm_load_o | dm_store_o, 32'd0);
    if (wr && rd != 5'd0) begin
      chk("alu_rf_index", rf_index_o, rd);
      chk("alu_rf_data", rf_data_o, val);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input int fun, input logic [4:0] rd,
                         input logic [31:0] data, input int waits);
    x_valid_i = 1'b1; x_load_i = 1'b1; x_store_i = 1'b0; x_fun_i = 3'(fun);
    x_addr_i = addr; x_rd_i = rd; x_rd_write_i = 1'b1; x_rd_value_i = $urandom;
    x_store_data_i = $urandom;
    tick();
    drive_idle();
    if (ref_misaligned(fun, addr)) begin
      chk("ld_mis_pulse", w_misaligned_o, 32'd1);
      chk("ld_mis_no_dm", dm_load_o | dm_store_o, 32'd0);
      chk("ld_mis_stall", w_stall_req_o, 32'd0);
      chk("ld_mis_rf", rf_write_o, 32'd0);
      return;
    end
    chk("ld_req", dm_load_o, 32'd1);
    chk("ld_no_st", dm_store_o, 32'd0);
    chk("ld_addr", dm_addr_o, addr - (addr % 4));
    chk("ld_stall", w_stall_req_o, 32'd1);
    chk("ld_mis", w_misaligned_o, 32'd0);
    for (int i = 0; i < waits; i++) begin
      drive_junk(1'b1);
      tick();
      chk("ld_wait_stall", w_stall_req_o, 32'd1);
      chk("ld_wait_quiet", dm_load_o | dm_store_o | rf_write_o, 32'd0);
    end
    drive_idle();
    dm_store_done_i = 1'b0; dm_load_done_i = 1'b1; dm_data_l_i = data;
    tick();
    dm_load_done_i = 1'b0; dm_data_l_i = $urandom;
    chk("ld_done_stall", w_stall_req_o, 32'd0);
    chk("ld_rf_write", rf_write_o, (rd != 5'd0) ? 32'd1 : 32'd0);
    if (rd != 5'd0) begin
      chk("ld_rf_index", rf_index_o, rd);
      chk("ld_rf_data", rf_data_o, ref_load(data, addr, fun));
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input int fun, input logic [31:0] sdata,
                          input int waits);
    x_valid_i = 1'b1; x_load_i = 1'b0; x_store_i = 1'b1; x_fun_i = 3'(fun);
    x_addr_i = addr; x_store_data_i = sdata; x_rd_i = 5'($urandom_range(1, 31));
    x_rd_write_i = 1'b1; x_rd_value_i = $urandom;
    tick();
    drive_idle();
    if (ref_misaligned(fun, addr)) begin
      chk("st_mis_pulse", w_misaligned_o, 32'd1);
      chk("st_mis_no_dm", dm_load_o | dm_store_o, 32'd0);
      chk("st_mis_stall", w_stall_req_o, 32'd0);
      chk("st_mis_rf", rf_write_o, 32'd0);
      return;
    end
    chk("st_req", dm_store_o, 32'd1);
    chk("st_no_ld", dm_load_o, 32'd0);
    chk("st_addr", dm_addr_o, addr - (addr % 4));
    chk("st_data", dm_data_s_o, ref_store_data(sdata, fun));
    chk("st_sel", dm_data_select_o, ref_store_sel(addr, fun));
    chk("st_stall", w_stall_req_o, 32'd1);
    chk("st_rf", rf_write_o, 32'd0);
    for (int i = 0; i < waits; i++) begin
      drive_junk(1'b0);
      tick();
      chk("st_wait_stall", w_stall_req_o, 32'd1);
      chk("st_wait_quiet", dm_load_o | dm_store_o | rf_write_o, 32'd0);
    end
    drive_idle();
    dm_load_done_i = 1'b0; dm_store_done_i = 1'b1;
    tick();
    dm_store_done_i = 1'b0;
    chk("st_done_stall", w_stall_req_o, 32'd0);
    chk("st_done_rf", rf_write_o, 32'd0);
  endtask

  initial begin
    int ld_funs [5] = '{0, 1, 2, 4, 5};
    logic [31:0] a;
    int f;
    int kind;

    // Reset state
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_stall", w_stall_req_o, 32'd0);
    chk("rst_mis", w_misaligned_o, 32'd0);
    chk("rst_strobes", {dm_load_o, dm_store_o, rf_write_o}, 32'd0);
    chk("rst_addr", dm_addr_o, 32'd0);
    chk("rst_data_s", dm_data_s_o, 32'd0);
    chk("rst_sel", dm_data_select_o, 32'd0);
    chk("rst_rf_index", rf_index_o, 32'd0);
    chk("rst_rf_data", rf_data_o, 32'd0);

    // Directed cases
    do_load(32'h100, 2, 5'd3, 32'h12345678, 0);
    do_load(32'h103, 0, 5'd4, 32'h80AABBCC, 1);
    do_load(32'h103, 4, 5'd4, 32'h80AABBCC, 2);
    do_store(32'h102, 1, 32'h0000BEEF, 5);
    do_load(32'h1001, 2, 5'd6, 32'hDEADBEEF, 0);
    do_alu(5'd5, 32'hAAAA0005, 1'b1);
    do_alu(5'd0, 32'hAAAA0000, 1'b1);
    do_alu(5'd7, 32'hAAAA0007, 1'b1);

    // Done strobes while idle are ignored
    dm_load_done_i = 1'b1; dm_store_done_i = 1'b1; dm_data_l_i = 32'hFFFFFFFF;
    tick();
    dm_load_done_i = 1'b0; dm_store_done_i = 1'b0;
    chk("idle_done_rf", rf_write_o, 32'd0);
    chk("idle_done_stall", w_stall_req_o, 32'd0);

    // Reset while waiting for a load; the late done must be dropped
    x_valid_i = 1'b1; x_load_i = 1'b1; x_fun_i = 3'd2; x_addr_i = 32'h200; x_rd_i = 5'd9;
    tick();
    drive_idle();
    chk("rstw_stall_pre", w_stall_req_o, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstw_stall_rst", w_stall_req_o, 32'd0);
    dm_load_done_i = 1'b1; dm_data_l_i = 32'h55AA55AA;
    tick();
    dm_load_done_i = 1'b0;
    chk("rstw_rf", rf_write_o, 32'd0);
    chk("rstw_stall", w_stall_req_o, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a - (a % 4) + 32'($urandom_range(0, 1) * 2);
      if (kind == 0) begin
        f = ld_funs[$urandom_range(0, 4)];
        do_load(a, f, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 4));
      end else if (kind == 1) begin
        do_store(a, $urandom_range(0, 2), $urandom, $urandom_range(0, 4));
      end else begin
        do_alu(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      end
    end
    drive_idle();
    tick();
    chk("end_quiet", {w_stall_req_o, rf_write_o, dm_load_o, dm_store_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
